// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data memory responder: FUNCT3 encodings,
// FSM state type, byte-enable and misalignment helpers.
package data_memory_responder_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_e;

    // Lane mask is shifted by the byte offset and truncated to 4 bits,
    // so misaligned stores simply lose the lanes past byte 3.
    function automatic logic [3:0] dmem_byte_en(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (funct3)
            FUNCT3_B: be = 4'b0001 << off;
            FUNCT3_H: be = 4'b0011 << off;
            FUNCT3_W: be = 4'b1111 << off;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Unsupported encodings differ between loads and stores: loads
    // also have the unsigned byte/half forms.
    function automatic logic dmem_misaligned(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic mis;
        case (funct3)
            FUNCT3_B:  mis = 1'b0;
            FUNCT3_BU: mis = we;
            FUNCT3_H:  mis = off[0];
            FUNCT3_HU: mis = we | off[0];
            FUNCT3_W:  mis = (off != 2'b00);
            default:   mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_memory_responder_byte_array.sv
// Word-organised storage with four byte-lane write enables and a
// registered read port. Ports: clk, we[3:0], addr, wdata, re, rdata.
module dmem_byte_array #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic [3:0]                we,
    input  logic [MEM_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]               wdata,
    input  logic                      re,
    output logic [31:0]               rdata
);

    logic [31:0] mem [2**MEM_ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder: one request at a time, WAIT_CYCLES wait states,
// byte-lane writes, raw word reads on a valid/ready response channel.
// Ports: clk, rst_n (sync, active-low), req_* request channel,
// resp_* response channel. Optional: DMEM_MISALIGN_ERR_EN flags
// misaligned/unsupported accesses on resp_err_o and suppresses them.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o
);

    localparam int AW    = MEM_ADDR_WIDTH + 2;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    dmem_state_e           state;
    logic [CNT_W-1:0]      cnt;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  resp_valid_q;
    logic                  err_q;

    logic                  commit;
    logic                  c_we;
    logic [2:0]            c_f3;
    logic [AW-1:0]         c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  c_mis;
    logic [3:0]            c_be;
    logic [3:0]            arr_we;
    logic                  arr_re;
    logic [31:0]           arr_rdata;
    logic                  unused_addr;

    assign unused_addr = ^req_addr_i[31:AW];

    assign req_ready_o = (state == DMEM_IDLE);

    // With zero wait states the commit edge is the accept edge, so the
    // commit uses the live request instead of the latched copy.
    assign c_we    = req_ready_o ? req_we_i          : we_q;
    assign c_f3    = req_ready_o ? req_funct3_i      : f3_q;
    assign c_addr  = req_ready_o ? req_addr_i[AW-1:0] : addr_q;
    assign c_wdata = req_ready_o ? req_wdata_i       : wdata_q;

    // Gated by rst_n so a reset on the commit edge drops the store.
    always_comb begin
        commit = 1'b0;
        if (rst_n) begin
            if (state == DMEM_IDLE) begin
                commit = req_valid_i && (WAIT_CYCLES == 0);
            end else if (state == DMEM_WAIT) begin
                commit = (cnt == CNT_W'(1));
            end
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign c_mis = dmem_misaligned(c_we, c_f3, c_addr[1:0]);
`else
    assign c_mis = 1'b0;
`endif

    assign c_be   = dmem_byte_en(c_f3, c_addr[1:0]) & {4{~c_mis}};
    assign arr_we = c_be & {4{commit & c_we}};
    assign arr_re = commit & ~c_we;

    dmem_byte_array #(
        .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (c_addr[AW-1:2]),
        .wdata(c_wdata),
        .re   (arr_re),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= DMEM_IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        f3_q    <= req_funct3_i;
                        addr_q  <= req_addr_i[AW-1:0];
                        wdata_q <= req_wdata_i;
                        if (WAIT_CYCLES == 0) begin
                            state        <= DMEM_RESP;
                            cnt          <= '0;
                            resp_valid_q <= 1'b1;
                            err_q        <= c_mis;
                        end else begin
                            state <= DMEM_WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                DMEM_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state        <= DMEM_RESP;
                        resp_valid_q <= 1'b1;
                        err_q        <= c_mis;
                    end
                end
                DMEM_RESP: begin
                    if (resp_ready_i) begin
                        state        <= DMEM_IDLE;
                        resp_valid_q <= 1'b0;
                        err_q        <= 1'b0;
                    end
                end
                default: begin
                    state <= DMEM_IDLE;
                end
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = err_q;
    // The read register only updates on a load commit, so it holds
    // steady for the whole RESP phase.
    assign resp_rdata_o = (resp_valid_q && !we_q && !err_q)
                        ? arr_rdata : '0;

endmodule
